// File: rtl/rsc_frame_encoder_if.sv
// Handshake and frame bus of the RSC frame encoder.
// The encoder uses the slave modport; the block source/sink side uses master.
interface rsc_frame_encoder_if #(
  parameter int K = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sys;
  logic         out_par;
  logic         out_tail;
  logic         out_last;
  logic [K-1:0] sys_frame;
  logic [K-1:0] par_frame;
  logic         frame_valid;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sys, out_par, out_tail, out_last,
           sys_frame, par_frame, frame_valid
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sys, out_par, out_tail, out_last,
           sys_frame, par_frame, frame_valid
  );
endinterface

// File: rtl/rsc_frame_encoder.sv
// Rate-1/2 4-state RSC encoder (feedback 7, feedforward 5) streaming K info
// symbols plus optional 2 tail symbols, and presenting the y1/y2 frame.
module rsc_frame_encoder #(
  parameter int K         = 10,
  parameter bit TERMINATE = 1'b1
) (
  input logic               clk,
  input logic               rst,
  rsc_frame_encoder_if.slave bus
);

  localparam int             IW         = (K > 2) ? $clog2(K) : 1;
  localparam logic [IW-1:0]  LAST_IDX   = IW'(K - 1);
  localparam logic [IW-1:0]  PENULT_IDX = IW'(K - 2);

  typedef enum logic [1:0] {IDLE, ENC, TAIL} state_e;

  state_e        fsm_q, fsm_d;
  logic [K-1:0]  data_q, data_d;
  logic [K-1:0]  sys_frame_q, sys_frame_d;
  logic [K-1:0]  par_frame_q, par_frame_d;
  logic          r1_q, r1_d;
  logic          r2_q, r2_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tcnt_q, tcnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sys_q, out_sys_d;
  logic          out_par_q, out_par_d;
  logic          out_tail_q, out_tail_d;
  logic          out_last_q, out_last_d;
  logic          frame_valid_q, frame_valid_d;

  logic          xfer;
  logic          f_cur;
  logic          frame_done;

  // The outputs always describe the symbol being offered, so every transfer
  // precomputes the next symbol from the post-update trellis state.
  always_comb begin
    fsm_d         = fsm_q;
    data_d        = data_q;
    sys_frame_d   = sys_frame_q;
    par_frame_d   = par_frame_q;
    r1_d          = r1_q;
    r2_d          = r2_q;
    idx_d         = idx_q;
    tcnt_d        = tcnt_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_sys_d     = out_sys_q;
    out_par_d     = out_par_q;
    out_tail_d    = out_tail_q;
    out_last_d    = out_last_q;
    frame_valid_d = 1'b0;
    frame_done    = 1'b0;

    xfer  = out_valid_q & bus.out_ready;
    f_cur = out_sys_q ^ r1_q ^ r2_q;

    case (fsm_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q) begin
          fsm_d       = ENC;
          data_d      = bus.in_data;
          sys_frame_d = bus.in_data;
          par_frame_d = '0;
          r1_d        = 1'b0;
          r2_d        = 1'b0;
          idx_d       = '0;
          tcnt_d      = 1'b0;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          // From state 00 the first parity bit equals the first info bit.
          out_sys_d   = bus.in_data[0];
          out_par_d   = bus.in_data[0];
          out_tail_d  = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      ENC: begin
        if (xfer) begin
          r1_d               = f_cur;
          r2_d               = r1_q;
          par_frame_d[idx_q] = out_par_q;
          data_d             = data_q >> 1;
          idx_d              = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            if (TERMINATE) begin
              fsm_d      = TAIL;
              tcnt_d     = 1'b0;
              out_sys_d  = f_cur ^ r1_q;
              out_par_d  = r1_q;
              out_tail_d = 1'b1;
              out_last_d = 1'b0;
            end else begin
              frame_done = 1'b1;
            end
          end else begin
            out_sys_d  = data_q[1];
            out_par_d  = data_q[1] ^ f_cur;
            out_last_d = !TERMINATE && (idx_q == PENULT_IDX);
          end
        end
      end

      TAIL: begin
        if (xfer) begin
          r1_d   = f_cur;
          r2_d   = r1_q;
          tcnt_d = 1'b1;
          if (tcnt_q) begin
            frame_done = 1'b1;
          end else begin
            out_sys_d  = r1_q;
            out_par_d  = r1_q;
            out_last_d = 1'b1;
          end
        end
      end

      default: fsm_d = IDLE;
    endcase

    if (frame_done) begin
      fsm_d         = IDLE;
      in_ready_d    = 1'b1;
      out_valid_d   = 1'b0;
      out_sys_d     = 1'b0;
      out_par_d     = 1'b0;
      out_tail_d    = 1'b0;
      out_last_d    = 1'b0;
      frame_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= IDLE;
      data_q        <= '0;
      sys_frame_q   <= '0;
      par_frame_q   <= '0;
      r1_q          <= 1'b0;
      r2_q          <= 1'b0;
      idx_q         <= '0;
      tcnt_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sys_q     <= 1'b0;
      out_par_q     <= 1'b0;
      out_tail_q    <= 1'b0;
      out_last_q    <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      data_q        <= data_d;
      sys_frame_q   <= sys_frame_d;
      par_frame_q   <= par_frame_d;
      r1_q          <= r1_d;
      r2_q          <= r2_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sys_q     <= out_sys_d;
      out_par_q     <= out_par_d;
      out_tail_q    <= out_tail_d;
      out_last_q    <= out_last_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sys     = out_sys_q;
  assign bus.out_par     = out_par_q;
  assign bus.out_tail    = out_tail_q;
  assign bus.out_last    = out_last_q;
  assign bus.sys_frame   = sys_frame_q;
  assign bus.par_frame   = par_frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Bench for rsc_frame_encoder: a terminated (d0) and an unterminated (d1)
// instance share stimulus and are checked against a recurrence-based model.
module tb_rsc_frame_encoder;

  localparam int K = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [K-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         ir [2];
  logic         ov [2];
  logic         osys [2];
  logic         opar [2];
  logic         otail [2];
  logic         olast [2];
  logic         fv [2];
  logic [K-1:0] sysf [2];
  logic [K-1:0] parf [2];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : gd
      rsc_frame_encoder_if #(.K(K)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_data   = in_data;
      assign bus.out_ready = out_ready;
      assign ir[g]    = bus.in_ready;
      assign ov[g]    = bus.out_valid;
      assign osys[g]  = bus.out_sys;
      assign opar[g]  = bus.out_par;
      assign otail[g] = bus.out_tail;
      assign olast[g] = bus.out_last;
      assign fv[g]    = bus.frame_valid;
      assign sysf[g]  = bus.sys_frame;
      assign parf[g]  = bus.par_frame;
      rsc_frame_encoder #(.K(K), .TERMINATE((g == 0) ? 1'b1 : 1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit           busy [2];
  bit           fresh [2];
  bit           fv_due [2];
  int           pos [2];
  int           len [2];
  logic [K+1:0] e_sys [2];
  logic [K+1:0] e_par [2];
  logic [K+1:0] e_tail [2];
  logic [K+1:0] e_last [2];
  logic [K-1:0] pend_par [2];
  logic [K-1:0] hold_sys [2];
  logic [K-1:0] hold_par [2];
  int           acc_cnt [2];
  int           done_cnt [2];
  int           acc_cyc [2];
  int           fin_cyc [2];
  int           sym_cnt [2];
  int           last_no [2];
  logic [15:0]  cap_sys [2];
  logic [15:0]  cap_par [2];
  logic [15:0]  cap_tail [2];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Feedback sequence f_i = u_i ^ f_(i-1) ^ f_(i-2), parity p_i = f_i ^ f_(i-2);
  // tail inputs are chosen so that f_i = 0.
  task automatic build_frame(input int d, input logic [K-1:0] data);
    logic [K+1:0] f;
    logic fm1, fm2, u;
    int n;
    n = K + ((d == 0) ? 2 : 0);
    f = '0;
    e_sys[d] = '0; e_par[d] = '0; e_tail[d] = '0; e_last[d] = '0;
    for (int i = 0; i < n; i++) begin
      fm1 = (i >= 1) ? f[i-1] : 1'b0;
      fm2 = (i >= 2) ? f[i-2] : 1'b0;
      u   = (i < K) ? data[i] : (fm1 ^ fm2);
      f[i] = u ^ fm1 ^ fm2;
      e_sys[d][i]  = u;
      e_par[d][i]  = f[i] ^ fm2;
      e_tail[d][i] = (i >= K);
      e_last[d][i] = (i == n - 1);
      if (i < K) pend_par[d][i] = f[i] ^ fm2;
    end
    len[d] = n;
  endtask

  // Compare process: checks every DUT output each cycle, then advances the
  // model by what the upcoming clock edge will do.
  always @(negedge clk) begin
    bit rdy_exp;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        checkOutput($sformatf("d%0d_rst_out_valid", d), ov[d], 0);
        checkOutput($sformatf("d%0d_rst_frame_valid", d), fv[d], 0);
        checkOutput($sformatf("d%0d_rst_in_ready", d), ir[d], 0);
        busy[d] = 0; fresh[d] = 1; fv_due[d] = 0; pos[d] = 0;
        hold_sys[d] = '0; hold_par[d] = '0; sym_cnt[d] = 0; last_no[d] = 0;
        cap_sys[d] = '0; cap_par[d] = '0; cap_tail[d] = '0;
      end else begin
        rdy_exp = !busy[d] && !fresh[d];
        checkOutput($sformatf("d%0d_in_ready", d), ir[d], rdy_exp);
        checkOutput($sformatf("d%0d_out_valid", d), ov[d], busy[d]);
        checkOutput($sformatf("d%0d_frame_valid", d), fv[d], fv_due[d]);
        checkOutput($sformatf("d%0d_sys_frame", d), sysf[d], hold_sys[d]);
        if (busy[d]) begin
          checkOutput($sformatf("d%0d_sym%0d_sys", d, pos[d]), osys[d], e_sys[d][pos[d]]);
          checkOutput($sformatf("d%0d_sym%0d_par", d, pos[d]), opar[d], e_par[d][pos[d]]);
          checkOutput($sformatf("d%0d_sym%0d_tail", d, pos[d]), otail[d], e_tail[d][pos[d]]);
          checkOutput($sformatf("d%0d_sym%0d_last", d, pos[d]), olast[d], e_last[d][pos[d]]);
        end else begin
          checkOutput($sformatf("d%0d_par_frame", d), parf[d], hold_par[d]);
        end
        fresh[d]  = 0;
        fv_due[d] = 0;
        if (busy[d] && out_ready) begin
          cap_sys[d][sym_cnt[d]]  = osys[d];
          cap_par[d][sym_cnt[d]]  = opar[d];
          cap_tail[d][sym_cnt[d]] = otail[d];
          if (olast[d]) last_no[d] = sym_cnt[d] + 1;
          sym_cnt[d]++;
          pos[d]++;
          if (pos[d] == len[d]) begin
            busy[d]     = 0;
            fv_due[d]   = 1;
            hold_par[d] = pend_par[d];
            fin_cyc[d]  = cyc;
            done_cnt[d]++;
          end
        end else if (rdy_exp && in_valid) begin
          build_frame(d, in_data);
          busy[d]     = 1;
          pos[d]      = 0;
          hold_sys[d] = in_data;
          acc_cnt[d]++;
          acc_cyc[d]  = cyc;
          sym_cnt[d]  = 0;
          last_no[d]  = 0;
          cap_sys[d]  = '0; cap_par[d] = '0; cap_tail[d] = '0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [K-1:0] data);
    int start;
    int n;
    start    = acc_cnt[0];
    n        = 0;
    in_data  = data;
    in_valid = 1'b1;
    while (acc_cnt[0] == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc_cnt[0] == start) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitFrame(input bit bp);
    int start;
    int n;
    start = done_cnt[0];
    n     = 0;
    while (done_cnt[0] == start && n < 400) begin
      @(posedge clk); #1;
      if (bp) out_ready = (n >= 6 && n <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
      else    out_ready = 1'b1;
      n++;
    end
    out_ready = 1'b1;
    if (done_cnt[0] == start) checkOutput("frame_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_unit_frame(input string tag);
    checkOutput({tag, "_par_frame"}, parf[0], 10'h1B7);
    checkOutput({tag, "_sys_frame"}, sysf[0], 10'h001);
    checkOutput({tag, "_sym_sys"}, cap_sys[0], 16'h0C01);
    checkOutput({tag, "_sym_par"}, cap_par[0], 16'h09B7);
    checkOutput({tag, "_sym_tail"}, cap_tail[0], 16'h0C00);
    checkOutput({tag, "_last_no"}, last_no[0], 12);
    checkOutput({tag, "_sym_cnt"}, sym_cnt[0], 12);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int n;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", ir[0], 0);
    checkOutput("reset_out_valid", ov[0], 0);
    checkOutput("reset_out_sys", osys[0], 0);
    checkOutput("reset_out_par", opar[0], 0);
    checkOutput("reset_out_tail", otail[0], 0);
    checkOutput("reset_out_last", olast[0], 0);
    checkOutput("reset_sys_frame", sysf[0], 0);
    checkOutput("reset_par_frame", parf[0], 0);
    checkOutput("reset_frame_valid", fv[0], 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_in_ready", ir[0], 1);

    $display("[TB] test 1: unit impulse, terminated and unterminated");
    applyStimulus(10'h001);
    waitFrame(1'b0);
    check_unit_frame("t1");
    checkOutput("t1_model_par", hold_par[0], 10'h1B7);
    checkOutput("t1_d1_par_frame", parf[1], 10'h1B7);
    checkOutput("t1_d1_last_no", last_no[1], 10);
    checkOutput("t1_d1_sym_cnt", sym_cnt[1], 10);
    checkOutput("t1_d1_sym_tail", cap_tail[1], 0);

    $display("[TB] test 2: all ones");
    applyStimulus(10'h3FF);
    waitFrame(1'b0);
    checkOutput("t2_par_frame", parf[0], 10'h36D);
    checkOutput("t2_model_par", hold_par[0], 10'h36D);
    checkOutput("t2_sym_sys", cap_sys[0], 16'h0FFF);
    checkOutput("t2_sym_par", cap_par[0], 16'h0B6D);

    $display("[TB] test 3: all zeros");
    applyStimulus(10'h000);
    waitFrame(1'b0);
    checkOutput("t3_par_frame", parf[0], 0);
    checkOutput("t3_sym_sys", cap_sys[0], 0);
    checkOutput("t3_sym_par", cap_par[0], 0);
    checkOutput("t3_sym_tail", cap_tail[0], 16'h0C00);

    $display("[TB] test 4: backpressure");
    applyStimulus(10'h001);
    waitFrame(1'b1);
    check_unit_frame("t4");

    $display("[TB] test 5: in_valid held across two blocks");
    start    = acc_cnt[0];
    n        = 0;
    in_data  = 10'h2A5;
    in_valid = 1'b1;
    while (acc_cnt[0] == start && n < 50) begin
      @(posedge clk); #1; n++;
    end
    in_data = 10'h15A;
    while (acc_cnt[0] < start + 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    checkOutput("t5_accepts", acc_cnt[0] - start, 2);
    checkOutput("t5_accept_gap", acc_cyc[0] - fin_cyc[0], 1);
    waitFrame(1'b0);
    checkOutput("t5_sys_frame", sysf[0], 10'h15A);

    $display("[TB] test 6: reset mid-frame then unit impulse");
    applyStimulus(10'h001);
    n = 0;
    while (sym_cnt[0] < 4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("t6_reached_sym5", sym_cnt[0], 4);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_out_valid", ov[0], 0);
    checkOutput("t6_rst_frame_valid", fv[0], 0);
    checkOutput("t6_rst_d1_out_valid", ov[1], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(10'h001);
    waitFrame(1'b0);
    check_unit_frame("t6");
    checkOutput("t6_d1_par_frame", parf[1], 10'h1B7);
    checkOutput("t6_d1_last_no", last_no[1], 10);
    checkOutput("t6_d1_sym_cnt", sym_cnt[1], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
